// File: rtl/quadrature_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_pkg
// Description : Shared FSM encoding, phase type and Gray-code mapping for the
//               quadrature generator and encoder_core.
// Revision    : 1.0 - initial release
// ============================================================================
package quadrature_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    // Forward sequence {a,b} indexed by phase: 00, 01, 11, 10
    localparam logic [7:0] c_GRAY_FWD = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] phase_to_ab(input phase_t phase);
        return c_GRAY_FWD[{phase, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/quadrature_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_generator_if
// Description : Command handshake and encoder output bundle for the generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface quadrature_generator_if #(
    parameter int STEP_W = 32,
    parameter int DIV_W  = 16
);
    logic                     enable;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic signed [STEP_W-1:0] cmd_steps;
    logic        [DIV_W-1:0]  cmd_period;
    logic                     enc_a;
    logic                     enc_b;
    logic                     busy;
    logic                     done;
    logic signed [STEP_W-1:0] position;

    modport master (
        output enable, cmd_valid, cmd_steps, cmd_period,
        input  cmd_ready, enc_a, enc_b, busy, done, position
    );

    modport slave (
        input  enable, cmd_valid, cmd_steps, cmd_period,
        output cmd_ready, enc_a, enc_b, busy, done, position
    );
endinterface
`default_nettype wire

// File: rtl/quadrature_generator_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : quad_step_timer
// Description : Loadable down-counter that ticks every i_period enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_step_timer #(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_load,
    input  wire logic             i_count_en,
    input  wire logic [DIV_W-1:0] i_period,
    output logic                  o_tick
);

    logic [DIV_W-1:0] r_count;

    // A count of 1 means this enabled cycle is the last of the interval
    assign o_tick = i_count_en && (r_count <= DIV_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_period;
        end else if (i_count_en) begin
            if (o_tick) begin
                r_count <= i_period;
            end else begin
                r_count <= r_count - DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/quadrature_generator.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_generator
// Description : Emits signed step commands as Gray-code edges on enc_a/enc_b.
// Revision    : 1.0 - initial release
// ============================================================================
module quadrature_generator
    import quadrature_pkg::*;
#(
    parameter int STEP_W = 32,
    parameter int DIV_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    quadrature_generator_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_dir;
    logic [STEP_W-1:0]   r_remaining;
    logic [DIV_W-1:0]    r_period;
    phase_t              r_phase;
    logic [1:0]          r_enc;
    logic [STEP_W-1:0]   r_position;

    logic                w_accept;
    logic                w_tick;
    logic [STEP_W-1:0]   w_steps_raw;
    logic [STEP_W-1:0]   w_steps_mag;
    logic [DIV_W-1:0]    w_period_in;
    logic [DIV_W-1:0]    w_timer_period;
    phase_t              w_phase_next;

    assign w_steps_raw = bus.cmd_steps;
    // Two's-complement magnitude; the most negative value maps to 2^(STEP_W-1)
    assign w_steps_mag = w_steps_raw[STEP_W-1] ? (~w_steps_raw + STEP_W'(1)) : w_steps_raw;
    assign w_period_in = (bus.cmd_period == '0) ? DIV_W'(1) : bus.cmd_period;
    assign w_timer_period = (r_state == ST_IDLE) ? w_period_in : r_period;
    assign w_phase_next = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);

    quad_step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept),
        .i_count_en (bus.enable && (r_state == ST_RUN)),
        .i_period   (w_timer_period),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.cmd_ready = bus.enable && reset_n;
                w_accept      = bus.enable && bus.cmd_valid;
                if (w_accept) begin
                    w_state_next = (w_steps_mag == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (w_tick && (r_remaining == STEP_W'(1))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Phase and position persist across commands; only reset clears them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_period    <= DIV_W'(1);
            r_phase     <= '0;
            r_enc       <= 2'b00;
            r_position  <= '0;
        end else if (w_accept) begin
            r_dir       <= w_steps_raw[STEP_W-1];
            r_remaining <= w_steps_mag;
            r_period    <= w_period_in;
        end else if (w_tick) begin
            r_remaining <= r_remaining - STEP_W'(1);
            r_phase     <= w_phase_next;
            r_enc       <= phase_to_ab(w_phase_next);
            r_position  <= r_dir ? (r_position - STEP_W'(1)) : (r_position + STEP_W'(1));
        end
    end

    assign bus.enc_a    = r_enc[1];
    assign bus.enc_b    = r_enc[0];
    assign bus.position = r_position;

endmodule
`default_nettype wire
